histo_frame_sequencer: RTL and testbench
========================================

Name: histo_frame_sequencer

Overview:
- Per-frame controller for the histogram RAM datapath: accumulator RAM, display RAM and cumulative RAM, all 256 x 20-bit dual-port, one clock, 1-cycle registered read.
- During a frame it performs hazard-free read-modify-write binning of grey pixels.
- After the frame it runs one flush pass that copies bins to the display RAM, writes the running cumulative sum to the cumulative RAM and clears each accumulator bin.
- Sits between the camera grey stream and the three RAM instances; display-side read ports are not driven here.

Parameters:
- PIX_BITS, 12, width of iGrey; bin index = iGrey[PIX_BITS-1 -: BIN_BITS]
- BIN_BITS, 8, bin address width (2^BIN_BITS bins)
- CNT_BITS, 20, bin count / cumulative width

Ports:
- iPclk  in  1  pixel clock; all logic on posedge
- iRst  in  1  reset, synchronous, active-high
- iFval  in  1  frame valid, high during frame
- iDval  in  1  pixel valid
- iGrey  in  PIX_BITS  grey pixel
- iAcc_Q  in  CNT_BITS  accumulator RAM read data (valid 1 cycle after address)
- oAcc_Rd_Addr  out  BIN_BITS  accumulator read address
- oAcc_Wr_Addr  out  BIN_BITS  accumulator write address
- oAcc_Wr_Data  out  CNT_BITS  accumulator write data
- oAcc_Wen  out  1  accumulator write enable
- oOut_Wr_Addr  out  BIN_BITS  shared write address, display and cumulative RAMs
- oDisp_Wr_Data  out  CNT_BITS  display RAM write data
- oCum_Wr_Data  out  CNT_BITS  cumulative RAM write data
- oOut_Wen  out  1  write enable, display and cumulative RAMs
- oPhase  out  2  0 IDLE, 1 ACCUM, 2 FLUSH, 3 INIT
- oFrame_Done  out  1  one-cycle pulse at end of FLUSH
- oOverrun  out  1  one-cycle pulse on iFval rise during FLUSH/INIT

Behaviour:
- Reset (iRst high at a clock edge):
  - state goes to INIT; bin counter = 0; all pipeline valids cleared.
  - All write enables and pulses are 0 while iRst is high; write data/address are 0.
  - Reset mid-pass aborts the pass; INIT restarts from bin 0.
- INIT (3): clears the accumulator.
  - Writes acc[k]=0 for k=0..255, one per cycle (256 cycles); oOut_Wen=0.
  - Then goes to IDLE. Display and cumulative RAMs are not touched.
- IDLE (0): no writes. On iFval 0->1 (registered edge detect) goes to ACCUM. A pixel on the rise cycle is counted.
- ACCUM (1):
  - oAcc_Rd_Addr = bin(iGrey) combinationally.
  - Stage register s1 <= {iDval, bin}.
  - Next cycle: oAcc_Wen = s1.valid, oAcc_Wr_Addr = s1.bin, oAcc_Wr_Data = sat(base+1).
  - Forwarding: base = (w.valid && w.bin==s1.bin) ? w.data : iAcc_Q, where w is the write issued in the previous cycle. This covers the RAM returning old data on a same-edge read/write.
  - Latency pixel->write = 1 cycle.
  - sat(): holds at 2^CNT_BITS-1, no wrap.
  - On iFval 1->0: the last pixel's write still completes (1-cycle drain), then state goes to FLUSH. Pixels with iFval low are ignored.
- FLUSH (2):
  - Cycle c=0..255: oAcc_Rd_Addr=c.
  - Cycle c+1: oOut_Wr_Addr=c, oDisp_Wr_Data=iAcc_Q, oCum_Wr_Data=sat(cum+iAcc_Q), oOut_Wen=1.
  - Same cycle c+1: acc[c]=0 (oAcc_Wen=1, addr c, data 0); cum register updated.
  - Total 257 cycles. cum is cleared on FLUSH entry.
  - After the bin-255 write: oFrame_Done=1 for one cycle, state goes to IDLE, cum=0.
- Overrun: iFval rise during FLUSH or INIT:
  - oOverrun pulses once; that frame is not accumulated (ACCUM entered only from IDLE).
  - The pass completes unaffected.
  - If iFval is still high on return to IDLE, wait for the next rise.
- Unused/default state decodes to INIT.

Test Plan:
- Reset, then 260 idle cycles -> oPhase 3 for 256 cycles with acc[0..255] written 0 in order, then oPhase 0; no oOut_Wen.
- Frame of 10 pixels grey=0x123 back-to-back (bin 0x12) -> writes 1,2,...,10 to acc[0x12] on consecutive cycles (forwarding); FLUSH writes disp[0x12]=10, cum[k]=0 for k<0x12 and 10 for k>=0x12; acc cleared; oFrame_Done after 257 FLUSH cycles.
- Alternating bins 0x00/0xFF, 6 pixels with iDval toggling every other cycle -> acc[0]=acc[255]=counts of valid pixels only; cum[255]=total valid count.
- Preload acc[5]=2^20-2 via model, 3 pixels bin 5 -> writes 0xFFFFF,0xFFFFF,0xFFFFF; cum saturates at 0xFFFFF.
- iFval rises at FLUSH cycle 100 -> oOverrun one pulse, no accumulator increments for that frame, FLUSH output identical to an unperturbed run.
- iRst asserted at FLUSH cycle 50 -> next cycle oPhase=3, bin 0 cleared, no oFrame_Done.

Source files
------------

// File: rtl/histo_frame_sequencer.sv
// rtl/histo_frame_sequencer.sv - per-frame histogram RAM sequencer: hazard-free binning, flush to display/cumulative RAMs, accumulator clear
module histo_frame_sequencer #(
  parameter int PIX_BITS = 12,
  parameter int BIN_BITS = 8,
  parameter int CNT_BITS = 20
) (
  input  logic                iPclk,
  input  logic                iRst,
  input  logic                iFval,
  input  logic                iDval,
  input  logic [PIX_BITS-1:0] iGrey,
  input  logic [CNT_BITS-1:0] iAcc_Q,
  output logic [BIN_BITS-1:0] oAcc_Rd_Addr,
  output logic [BIN_BITS-1:0] oAcc_Wr_Addr,
  output logic [CNT_BITS-1:0] oAcc_Wr_Data,
  output logic                oAcc_Wen,
  output logic [BIN_BITS-1:0] oOut_Wr_Addr,
  output logic [CNT_BITS-1:0] oDisp_Wr_Data,
  output logic [CNT_BITS-1:0] oCum_Wr_Data,
  output logic                oOut_Wen,
  output logic [1:0]          oPhase,
  output logic                oFrame_Done,
  output logic                oOverrun
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_FLUSH = 2'd2,
    S_INIT  = 2'd3
  } state_t;

  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE  = 1;
  localparam logic [BIN_BITS-1:0] BIN_LAST = '1;
  localparam logic [BIN_BITS-1:0] BIN_ONE  = 1;
  localparam logic [BIN_BITS:0]   PASS_ONE = 1;

  state_t              r_state, w_next;
  logic [BIN_BITS:0]   r_cnt, w_cnt_next;
  logic                r_fval_d;
  logic                r_s1_valid, w_s1_valid_next;
  logic [BIN_BITS-1:0] r_s1_bin;
  logic                r_w_valid;
  logic [BIN_BITS-1:0] r_w_bin;
  logic [CNT_BITS-1:0] r_w_data;
  logic [CNT_BITS-1:0] r_cum, w_cum_next;

  logic [BIN_BITS-1:0] w_bin;
  logic                w_rise;
  logic [CNT_BITS-1:0] w_base;
  logic [CNT_BITS-1:0] w_inc;
  logic [CNT_BITS:0]   w_sum;
  logic [CNT_BITS-1:0] w_cum_sat;
  logic [BIN_BITS-1:0] w_prev_bin;
  logic                w_unused_grey_lsbs;

  assign w_bin              = iGrey[PIX_BITS-1 -: BIN_BITS];
  assign w_unused_grey_lsbs = ^iGrey[PIX_BITS-BIN_BITS-1:0];
  assign w_rise             = iFval & ~r_fval_d;

  // The RAM returns pre-write data when the previous cycle wrote the same bin.
  assign w_base    = (r_w_valid && (r_w_bin == r_s1_bin)) ? r_w_data : iAcc_Q;
  assign w_inc     = (w_base == CNT_MAX) ? CNT_MAX : w_base + CNT_ONE;
  assign w_sum     = {1'b0, r_cum} + {1'b0, iAcc_Q};
  assign w_cum_sat = w_sum[CNT_BITS] ? CNT_MAX : w_sum[CNT_BITS-1:0];
  assign w_prev_bin = r_cnt[BIN_BITS-1:0] - BIN_ONE;
  assign oPhase    = r_state;

  always_comb begin
    w_next          = r_state;
    w_cnt_next      = r_cnt;
    w_cum_next      = r_cum;
    w_s1_valid_next = 1'b0;
    oAcc_Rd_Addr    = '0;
    oAcc_Wr_Addr    = '0;
    oAcc_Wr_Data    = '0;
    oAcc_Wen        = 1'b0;
    oOut_Wr_Addr    = '0;
    oDisp_Wr_Data   = '0;
    oCum_Wr_Data    = '0;
    oOut_Wen        = 1'b0;
    oFrame_Done     = 1'b0;
    oOverrun        = 1'b0;

    case (r_state)
      S_INIT: begin
        oOverrun     = w_rise;
        oAcc_Wen     = 1'b1;
        oAcc_Wr_Addr = r_cnt[BIN_BITS-1:0];
        w_cnt_next   = r_cnt + PASS_ONE;
        if (r_cnt[BIN_BITS-1:0] == BIN_LAST) begin
          w_next     = S_IDLE;
          w_cnt_next = '0;
        end
      end
      S_IDLE: begin
        oAcc_Rd_Addr = w_bin;
        if (w_rise) begin
          w_next          = S_ACCUM;
          w_s1_valid_next = iDval;
        end
      end
      S_ACCUM: begin
        oAcc_Rd_Addr    = w_bin;
        oAcc_Wen        = r_s1_valid;
        oAcc_Wr_Addr    = r_s1_bin;
        oAcc_Wr_Data    = r_s1_valid ? w_inc : '0;
        w_s1_valid_next = iDval & iFval;
        if (!iFval) begin
          w_next     = S_FLUSH;
          w_cnt_next = '0;
          w_cum_next = '0;
        end
      end
      S_FLUSH: begin
        oOverrun = w_rise;
        if (!r_cnt[BIN_BITS]) oAcc_Rd_Addr = r_cnt[BIN_BITS-1:0];
        // Bin c is read on pass step c and emitted/cleared on step c+1.
        if (r_cnt != '0) begin
          oOut_Wen      = 1'b1;
          oOut_Wr_Addr  = w_prev_bin;
          oDisp_Wr_Data = iAcc_Q;
          oCum_Wr_Data  = w_cum_sat;
          oAcc_Wen      = 1'b1;
          oAcc_Wr_Addr  = w_prev_bin;
          w_cum_next    = w_cum_sat;
        end
        if (r_cnt[BIN_BITS]) begin
          oFrame_Done = 1'b1;
          w_next      = S_IDLE;
          w_cnt_next  = '0;
          w_cum_next  = '0;
        end else begin
          w_cnt_next = r_cnt + PASS_ONE;
        end
      end
      default: begin
        w_next     = S_INIT;
        w_cnt_next = '0;
      end
    endcase

    if (iRst) begin
      w_next          = S_INIT;
      w_cnt_next      = '0;
      w_cum_next      = '0;
      w_s1_valid_next = 1'b0;
      oAcc_Rd_Addr    = '0;
      oAcc_Wr_Addr    = '0;
      oAcc_Wr_Data    = '0;
      oAcc_Wen        = 1'b0;
      oOut_Wr_Addr    = '0;
      oDisp_Wr_Data   = '0;
      oCum_Wr_Data    = '0;
      oOut_Wen        = 1'b0;
      oFrame_Done     = 1'b0;
      oOverrun        = 1'b0;
    end
  end

  always_ff @(posedge iPclk) begin
    r_fval_d <= iFval;
    r_s1_bin <= w_bin;
    r_w_bin  <= oAcc_Wr_Addr;
    r_w_data <= oAcc_Wr_Data;
    if (iRst) begin
      r_state    <= S_INIT;
      r_cnt      <= '0;
      r_cum      <= '0;
      r_s1_valid <= 1'b0;
      r_w_valid  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_cum      <= w_cum_next;
      r_s1_valid <= w_s1_valid_next;
      r_w_valid  <= oAcc_Wen;
    end
  end

endmodule

// File: tb/tb_histo_frame_sequencer.sv
// tb/tb_histo_frame_sequencer.sv - scoreboard bench for histo_frame_sequencer with frame-level histogram model
module tb_histo_frame_sequencer;

  localparam int     NB   = 256;
  localparam longint MAXC = (64'd1 << 20) - 1;

  typedef struct {
    logic [7:0]  a;
    logic [19:0] d;
  } acc_ev_t;

  typedef struct {
    logic [7:0]  a;
    logic [19:0] disp;
    logic [19:0] cum;
  } out_ev_t;

  logic        clk = 1'b0;
  logic        iRst = 1'b1;
  logic        iFval = 1'b0;
  logic        iDval = 1'b0;
  logic [11:0] iGrey = '0;
  logic [19:0] iAcc_Q;
  logic [7:0]  oAcc_Rd_Addr, oAcc_Wr_Addr, oOut_Wr_Addr;
  logic [19:0] oAcc_Wr_Data, oDisp_Wr_Data, oCum_Wr_Data;
  logic        oAcc_Wen, oOut_Wen, oFrame_Done, oOverrun;
  logic [1:0]  oPhase;

  always #5 clk = ~clk;

  histo_frame_sequencer #(.PIX_BITS(12), .BIN_BITS(8), .CNT_BITS(20)) dut (
    .iPclk(clk), .iRst(iRst), .iFval(iFval), .iDval(iDval), .iGrey(iGrey),
    .iAcc_Q(iAcc_Q), .oAcc_Rd_Addr(oAcc_Rd_Addr), .oAcc_Wr_Addr(oAcc_Wr_Addr),
    .oAcc_Wr_Data(oAcc_Wr_Data), .oAcc_Wen(oAcc_Wen), .oOut_Wr_Addr(oOut_Wr_Addr),
    .oDisp_Wr_Data(oDisp_Wr_Data), .oCum_Wr_Data(oCum_Wr_Data), .oOut_Wen(oOut_Wen),
    .oPhase(oPhase), .oFrame_Done(oFrame_Done), .oOverrun(oOverrun)
  );

  // Accumulator RAM: registered read, old data on same-address read/write.
  logic [19:0] ram_acc [NB];
  logic [19:0] acc_q;
  logic        pre_en = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [19:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_en) ram_acc[pre_addr] <= pre_data;
    else if (oAcc_Wen) ram_acc[oAcc_Wr_Addr] <= oAcc_Wr_Data;
    acc_q <= ram_acc[oAcc_Rd_Addr];
  end
  assign iAcc_Q = acc_q;

  longint  m_acc [NB];
  acc_ev_t acc_exp[$];
  out_ev_t out_exp[$];
  int      done_q[$];
  logic [11:0] pg[$];
  logic        pd[$];
  int n_checks = 0;
  int n_fail   = 0;
  int exp_ovr  = 0;
  int got_ovr  = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_init();
    for (int k = 0; k < NB; k++) acc_exp.push_back('{8'(k), 20'd0});
  endtask

  // Flush expectations: display = bin count, cumulative = prefix sum clipped at max.
  task automatic push_flush();
    longint run;
    run = 0;
    for (int k = 0; k < NB; k++) begin
      run += m_acc[k];
      acc_exp.push_back('{8'(k), 20'd0});
      out_exp.push_back('{8'(k), 20'(m_acc[k]), 20'((run > MAXC) ? MAXC : run)});
      m_acc[k] = 0;
    end
    done_q.push_back(1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (oPhase != 2'd0 && n < 2000) begin
      tick();
      n++;
    end
    check("wait_idle", oPhase, 0);
  endtask

  task automatic check_init_len();
    int n;
    n = 0;
    while (oPhase == 2'd3 && n < 400) begin
      tick();
      n++;
    end
    check("init_len", n, 256);
    check("init_to_idle", oPhase, 0);
  endtask

  task automatic gen_random(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 4))
        0: b = 8'h12;
        1: b = 8'h13;
        2: b = 8'h80;
        3: b = 8'hFF;
        default: b = 8'($urandom);
      endcase
      pg.push_back({b, 4'($urandom)});
      pd.push_back($urandom_range(0, 3) != 0);
    end
  endtask

  // mode 0: plain frame; 1: iFval rises at flush step 100; 2: reset at flush step 50
  task automatic drive_frame(input int mode);
    logic [11:0] g;
    logic [7:0]  b;
    int n, fc;
    bit aborted;
    aborted = 0;
    wait_idle();
    for (int i = 0; i < pg.size(); i++) begin
      g = pg[i];
      iFval = 1'b1;
      iDval = pd[i];
      iGrey = g;
      if (pd[i]) begin
        b = g[11:4];
        m_acc[b] = (m_acc[b] + 1 > MAXC) ? MAXC : m_acc[b] + 1;
        acc_exp.push_back('{b, 20'(m_acc[b])});
      end
      tick();
    end
    iFval = 1'b0;
    iDval = 1'b0;
    push_flush();
    n = 0;
    while (oPhase != 2'd2 && n < 50) begin
      tick();
      n++;
    end
    check("flush_start", oPhase, 2);
    fc = 0;
    while (oPhase == 2'd2 && fc < 400) begin
      if (mode == 1 && fc == 100) begin
        iFval = 1'b1;
        iDval = 1'b1;
        iGrey = 12'($urandom);
        exp_ovr++;
      end else if (mode == 1 && fc > 100) begin
        iGrey = 12'($urandom);
        iDval = 1'($urandom_range(0, 1));
      end
      if (mode == 2 && fc == 50) begin
        iRst = 1'b1;
        #1;
        check("rst_gate_acc_wen", oAcc_Wen, 0);
        check("rst_gate_out_wen", oOut_Wen, 0);
        tick();
        iRst = 1'b0;
        acc_exp.delete();
        out_exp.delete();
        done_q.delete();
        for (int k = 0; k < NB; k++) m_acc[k] = 0;
        push_init();
        check("rst_mid_flush_phase", oPhase, 3);
        check_init_len();
        aborted = 1;
        break;
      end
      tick();
      fc++;
    end
    if (!aborted) begin
      check("flush_len", fc, 257);
      check("post_flush_phase", oPhase, 0);
    end
    if (mode == 1) begin
      repeat (20) begin
        iGrey = 12'($urandom);
        iDval = 1'b1;
        tick();
      end
      iFval = 1'b0;
      iDval = 1'b0;
      tick();
    end
    pg.delete();
    pd.delete();
  endtask

  always @(negedge clk) begin
    acc_ev_t ae;
    out_ev_t oe;
    if (oAcc_Wen) begin
      check("acc_write_expected", acc_exp.size() > 0, 1);
      if (acc_exp.size() > 0) begin
        ae = acc_exp.pop_front();
        check("acc_addr", oAcc_Wr_Addr, ae.a);
        check("acc_data", oAcc_Wr_Data, ae.d);
      end
    end
    if (oOut_Wen) begin
      check("out_write_expected", out_exp.size() > 0, 1);
      if (out_exp.size() > 0) begin
        oe = out_exp.pop_front();
        check("out_addr", oOut_Wr_Addr, oe.a);
        check("disp_data", oDisp_Wr_Data, oe.disp);
        check("cum_data", oCum_Wr_Data, oe.cum);
      end
    end
    if (oFrame_Done) begin
      check("done_expected", done_q.size() > 0, 1);
      if (done_q.size() > 0) void'(done_q.pop_front());
      check("done_after_last_out", out_exp.size(), 0);
    end
    if (oOverrun) got_ovr++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < NB; k++) m_acc[k] = 0;
    repeat (3) tick();
    check("rst_acc_wen", oAcc_Wen, 0);
    check("rst_out_wen", oOut_Wen, 0);
    check("rst_done", oFrame_Done, 0);
    check("rst_phase", oPhase, 3);
    iRst = 1'b0;
    push_init();
    check_init_len();
    repeat (4) tick();

    for (int i = 0; i < 10; i++) begin
      pg.push_back(12'h123);
      pd.push_back(1'b1);
    end
    drive_frame(0);

    for (int i = 0; i < 6; i++) begin
      pg.push_back((i % 2 == 0) ? 12'h005 : 12'hFFA);
      pd.push_back(((i / 2) % 2) == 0);
    end
    drive_frame(0);

    wait_idle();
    pre_en   = 1'b1;
    pre_addr = 8'h05;
    pre_data = 20'hFFFFE;
    tick();
    pre_en   = 1'b0;
    m_acc[5] = MAXC - 1;
    for (int i = 0; i < 3; i++) begin
      pg.push_back(12'h05A);
      pd.push_back(1'b1);
    end
    drive_frame(0);

    for (int f = 0; f < 5; f++) begin
      gen_random($urandom_range(1, 40));
      drive_frame(0);
    end

    gen_random(8);
    drive_frame(1);

    gen_random(12);
    drive_frame(2);

    gen_random(25);
    drive_frame(0);

    wait_idle();
    repeat (5) tick();
    check("acc_queue_drained", acc_exp.size(), 0);
    check("out_queue_drained", out_exp.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    check("overrun_count", got_ovr, exp_ovr);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
